// File: rtl/loader_pkg.sv
// Shared types and default parameters for the UART instruction loader.
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_END_WORDS  = 2;
    localparam int DEF_LSB_FIRST  = 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/loader_word_pack.sv
// Shifts received bytes into an instruction word and flags the byte that completes it.
// word_ready_o is combinational on the filling byte; word_o is the registered word.
module loader_word_pack
    import loader_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int LSB_FIRST  = DEF_LSB_FIRST
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         byte_vld_i,
    input  logic [BYTE_W-1:0]            byte_dat_i,
    input  logic                         flush_i,
    output logic                         word_ready_o,
    output logic [WORD_BYTES*BYTE_W-1:0] word_o
);

    localparam int WORD_W = WORD_BYTES * BYTE_W;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last;

    assign last = (cnt_q == CNT_W'(WORD_BYTES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (flush_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_vld_i) begin
            // Shifting keeps the first byte at the low (or high) end once the word is full.
            if (LSB_FIRST != 0)
                word_d = (word_q >> BYTE_W) | (WORD_W'(byte_dat_i) << (WORD_W - BYTE_W));
            else
                word_d = (word_q << BYTE_W) | WORD_W'(byte_dat_i);
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_ready_o = byte_vld_i & ~flush_i & last;
    assign word_o       = word_q;

endmodule

// File: rtl/uart_inst_loader.sv
// Assembles UART bytes into instruction words and writes them to memory until a run of
// all-ones words ends the load. LOADER_CHECKSUM_EN adds an XOR checksum output.
module uart_inst_loader
    import loader_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int END_WORDS  = DEF_END_WORDS,
    parameter int LSB_FIRST  = DEF_LSB_FIRST
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         rx_en,
    input  logic                         rx_valid,
    input  logic [BYTE_W-1:0]            rx_data,
    input  logic                         rx_break,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_BYTES*BYTE_W-1:0] mem_wdata,
    output logic                         write_done,
    output logic                         overflow,
    output logic [ADDR_W:0]              word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WORD_BYTES*BYTE_W-1:0] checksum
`endif
);

    localparam int WORD_W = WORD_BYTES * BYTE_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [3:0] END_N = 4'(END_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        run_q, run_inc;
    logic              done_q, ovf_q;
    logic              accept, flush, word_ready, all_ones, term, at_top;
    logic [WORD_W-1:0] word;

    // Bytes arriving with a BREAK, or after loading finished, are dropped.
    assign accept = rx_valid & rx_en & ~rx_break & (state_q != ST_DONE);
    assign flush  = rx_break & (state_q == ST_COLLECT);

    loader_word_pack #(
        .WORD_BYTES (WORD_BYTES),
        .LSB_FIRST  (LSB_FIRST)
    ) u_pack (
        .clk          (clk),
        .resetn       (resetn),
        .byte_vld_i   (accept),
        .byte_dat_i   (rx_data),
        .flush_i      (flush),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    assign all_ones = &word;
    assign run_inc  = run_q + 4'd1;
    assign term     = all_ones && (run_inc == END_N);
    assign at_top   = (ptr_q == '1);

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_COLLECT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_COLLECT: if (word_ready) state_d = ST_WRITE;
            ST_WRITE: begin
                if (term || at_top)  state_d = ST_DONE;
                else if (word_ready) state_d = ST_WRITE;
                else                 state_d = ST_COLLECT;
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_comb begin
        mem_we     = (state_q == ST_WRITE);
        mem_addr   = ptr_q;
        mem_wdata  = word;
        write_done = done_q;
        overflow   = ovf_q;
        word_count = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            // The pointer parks on the last address rather than wrapping.
            ptr_q  <= at_top ? ptr_q : ptr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
            run_q  <= all_ones ? run_inc : 4'd0;
            done_q <= term || at_top;
            ovf_q  <= at_top && !term;
        end else if (flush) begin
            run_q <= '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            csum_q <= '0;
        else if (state_q == ST_WRITE && !all_ones)
            csum_q <= csum_q ^ word;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: doc/uart_inst_loader.md
UART_INST_LOADER -- requirements
Module: uart_inst_loader

Interface
REQ-001 Parameter WORD_BYTES, default 4, SHALL set bytes per instruction word; WORD_W = 8*WORD_BYTES.
REQ-002 Parameter ADDR_W, default 8, SHALL set the memory word-address width.
REQ-003 Parameter END_WORDS, default 2, range 1..15, SHALL set how many consecutive all-ones words terminate loading.
REQ-004 Parameter LSB_FIRST, default 1, SHALL select byte order: 1 places the first byte in bits [7:0]; 0 places it in the top byte.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 rx_en  input  1  load enable; bytes ignored while low.
REQ-008 rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
REQ-009 rx_data  input  8  received UART byte.
REQ-010 rx_break  input  1  UART BREAK seen; one-cycle strobe.
REQ-011 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  word address for the write.
REQ-013 mem_wdata  output  WORD_W  assembled word.
REQ-014 write_done  output  1  sticky; loading complete.
REQ-015 overflow  output  1  sticky; memory filled before the terminator.
REQ-016 word_count  output  ADDR_W+1  words written, terminator words included.

Function
REQ-017 FSM states SHALL be COLLECT, WRITE and DONE; reset enters COLLECT.
REQ-018 COLLECT: each rx_valid with rx_en=1 SHALL shift rx_data into the assembly register and increment the byte counter (0..WORD_BYTES-1).
REQ-019 On the byte that fills the word, the FSM SHALL enter WRITE; mem_we SHALL be high exactly one cycle later, with mem_wdata holding the word and mem_addr equal to the current write pointer.
REQ-020 In WRITE the pointer and word_count SHALL increment, the byte counter SHALL clear, and the FSM SHALL return to COLLECT on the next cycle.
REQ-021 The all-ones run counter SHALL increment when the written word is all ones and clear otherwise; on reaching END_WORDS the FSM SHALL enter DONE and set write_done in the same cycle.
REQ-022 A write to address 2^ADDR_W-1 that does not complete the terminator SHALL set overflow and enter DONE with write_done=1; the pointer SHALL NOT wrap.
REQ-023 rx_break in COLLECT SHALL discard the partial word and clear the byte counter and the all-ones run counter; the pointer SHALL be unchanged.
REQ-024 rx_valid in the same cycle as rx_break SHALL be discarded.
REQ-025 In WRITE, rx_valid SHALL be accepted as byte 0 of the next word; back-to-back bytes SHALL never be lost.
REQ-026 In DONE all inputs except resetn SHALL be ignored; mem_we SHALL stay 0.
REQ-027 Deasserting rx_en mid-word SHALL hold the partial word; collection resumes when rx_en returns high.

Reset
REQ-028 While resetn=0 at a clk edge: mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, overflow=0, word_count=0, and all counters cleared.
REQ-029 Reset mid-word or in DONE SHALL abandon all progress; no write SHALL be issued on the following cycle.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, output checksum[WORD_W-1:0] SHALL hold the XOR of all written non-terminator words, reset to 0, and freeze in DONE.
REQ-031 Without LOADER_CHECKSUM_EN the checksum port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-032 Package loader_pkg SHALL hold the FSM state typedef, the byte width (8) and the default parameter constants.
REQ-033 Sub-module loader_word_pack SHALL implement byte shifting, the byte counter and LSB_FIRST ordering, and assert word_ready.

Verification
REQ-034 Bytes 13 01 01 fd -> one mem_we, addr 0, wdata 32'hfd010113.
REQ-035 Words 00000013, ffffffff, 00000093, ffffffff, ffffffff -> 5 writes; write_done after the 5th; word_count=5; checksum 32'h00000080 when enabled.
REQ-036 Bytes 11 22, rx_break, then bytes 33 44 55 66 -> single write of 32'h66554433 at addr 0.
REQ-037 ADDR_W=2, five non-terminator words -> 4 writes at addr 0..3; overflow=1; write_done=1; 5th word ignored.
REQ-038 LSB_FIRST=0, bytes fd 01 01 13 -> wdata 32'hfd010113.
REQ-039 Reset asserted after 2 bytes of word 3 -> all outputs 0; next full word written at addr 0.
